// File: rtl/arbiter_puf_pkg.sv
// Shared definitions for the arbiter PUF emulation engine.
//   - state_e       : FSM state encoding
//   - SEL_*         : challenge-bit meaning for one switch stage
//   - tw_of()       : arrival-time width, wide enough that N_STAGES additions
//                     of all-ones DW-bit delays cannot overflow
package arbiter_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_RACE  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic SEL_STRAIGHT = 1'b1;
  localparam logic SEL_CROSSED  = 1'b0;

  function automatic int tw_of(input int n_stages, input int dw);
    return dw + $clog2(n_stages) + 1;
  endfunction

endpackage

// File: rtl/puf_stage_step.sv
// One switch stage of the emulated delay chain (purely combinational).
// Ports:
//   t1_i, t2_i : arrival times entering the stage (TW bits)
//   sel_i      : 1 = straight, 0 = crossed
//   d1_i, d2_i : delay of the line-1 / line-2 output of this stage (DW bits)
//   t1_o, t2_o : arrival times leaving the stage (TW bits)
module puf_stage_step
  import arbiter_puf_pkg::*;
#(
  parameter int DW = 8,
  parameter int TW = 12
) (
  input  logic [TW-1:0] t1_i,
  input  logic [TW-1:0] t2_i,
  input  logic          sel_i,
  input  logic [DW-1:0] d1_i,
  input  logic [DW-1:0] d2_i,
  output logic [TW-1:0] t1_o,
  output logic [TW-1:0] t2_o
);

  logic [TW-1:0] src1;
  logic [TW-1:0] src2;

  always_comb begin
    if (sel_i == SEL_STRAIGHT) begin
      src1 = t1_i;
      src2 = t2_i;
    end else begin
      src1 = t2_i;
      src2 = t1_i;
    end
    t1_o = src1 + TW'(d1_i);
    t2_o = src2 + TW'(d2_i);
  end

endmodule

// File: rtl/arbiter_puf_engine.sv
// Arbiter PUF emulation engine. A challenge selects straight/crossed routing
// per stage; the two arrival times are accumulated one stage per clock, then a
// race counter counts up to the earlier arrival and the arbiter decision is
// registered when it gets there.
// Ports:
//   clk, rst            : clock, async active-high reset
//   ch_valid/ch_ready   : challenge handshake, challenge[N_STAGES-1:0]
//   resp_valid/ready    : response handshake, resp = 1 when line 1 wins
//   t1_out, t2_out      : final arrival times (TW bits)
//   eval_count          : completed evaluations, saturating
module arbiter_puf_engine
  import arbiter_puf_pkg::*;
#(
  parameter int                     N_STAGES = 8,
  parameter int                     DW       = 8,
  parameter logic [N_STAGES*DW-1:0] DELAY1   = {N_STAGES{8'b00001111}},
  parameter logic [N_STAGES*DW-1:0] DELAY2   = {N_STAGES{8'b00001111}},
  parameter logic                   TIE_RESP = 1'b0,
  localparam int                    TW       = tw_of(N_STAGES, DW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch_valid,
  output logic                ch_ready,
  input  logic [N_STAGES-1:0] challenge,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp,
  output logic [TW-1:0]       t1_out,
  output logic [TW-1:0]       t2_out,
  output logic [15:0]         eval_count
);

  localparam int             IW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_STAGES - 1);

  state_e              state_q, state_d;
  logic [N_STAGES-1:0] ch_q, ch_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       t1_q, t1_d;
  logic [TW-1:0]       t2_q, t2_d;
  logic                resp_q, resp_d;
  logic [15:0]         evc_q, evc_d;

  logic [DW-1:0]       step_d1;
  logic [DW-1:0]       step_d2;
  logic [TW-1:0]       step_t1;
  logic [TW-1:0]       step_t2;
  logic [TW-1:0]       tmin;

  // The single stage datapath is time-shared: idx_q picks which stage's
  // delays and challenge bit feed it on each ACCUM cycle.
  assign step_d1 = DELAY1[int'(idx_q)*DW +: DW];
  assign step_d2 = DELAY2[int'(idx_q)*DW +: DW];

  puf_stage_step #(
    .DW (DW),
    .TW (TW)
  ) u_step (
    .t1_i  (t1_q),
    .t2_i  (t2_q),
    .sel_i (ch_q[idx_q]),
    .d1_i  (step_d1),
    .d2_i  (step_d2),
    .t1_o  (step_t1),
    .t2_o  (step_t2)
  );

  assign tmin = (t1_q < t2_q) ? t1_q : t2_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    resp_d  = resp_q;
    evc_d   = evc_q;

    case (state_q)
      ST_IDLE: begin
        if (ch_valid) begin
          ch_d    = challenge;
          t1_d    = '0;
          t2_d    = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        t1_d = step_t1;
        t2_d = step_t2;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_RACE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RACE: begin
        // Counter reaching the earlier arrival models the arbiter firing.
        if (cnt_q == tmin) begin
          if (t1_q < t2_q)      resp_d = 1'b1;
          else if (t1_q > t2_q) resp_d = 1'b0;
          else                  resp_d = TIE_RESP;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          if (evc_q != 16'hFFFF) evc_d = evc_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      resp_q  <= 1'b0;
      evc_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      resp_q  <= resp_d;
      evc_q   <= evc_d;
    end
  end

  assign ch_ready   = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp       = resp_q;
  assign t1_out     = t1_q;
  assign t2_out     = t2_q;
  assign eval_count = evc_q;

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Bench for arbiter_puf_engine. Three instances:
//   0: N=4, DW=4, D1=2, D2=3, TIE_RESP=0
//   1: same delays, TIE_RESP=1
//   2: N=4, DW=4, all delays 0, TIE_RESP=1
module tb_arbiter_puf_engine;

  localparam int TW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [3];
  logic          ch_valid   [3];
  logic [3:0]    challenge  [3];
  logic          resp_ready [3];
  logic          ch_ready   [3];
  logic          resp_valid [3];
  logic          resp_w     [3];
  logic [TW-1:0] t1_w       [3];
  logic [TW-1:0] t2_w       [3];
  logic [15:0]   cnt_w      [3];

  arbiter_puf_engine #(.N_STAGES(4), .DW(4), .DELAY1(16'h2222), .DELAY2(16'h3333),
                       .TIE_RESP(1'b0)) dut0 (
    .clk(clk), .rst(rst[0]), .ch_valid(ch_valid[0]), .ch_ready(ch_ready[0]),
    .challenge(challenge[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp(resp_w[0]), .t1_out(t1_w[0]), .t2_out(t2_w[0]), .eval_count(cnt_w[0]));

  arbiter_puf_engine #(.N_STAGES(4), .DW(4), .DELAY1(16'h2222), .DELAY2(16'h3333),
                       .TIE_RESP(1'b1)) dut1 (
    .clk(clk), .rst(rst[1]), .ch_valid(ch_valid[1]), .ch_ready(ch_ready[1]),
    .challenge(challenge[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp(resp_w[1]), .t1_out(t1_w[1]), .t2_out(t2_w[1]), .eval_count(cnt_w[1]));

  arbiter_puf_engine #(.N_STAGES(4), .DW(4), .DELAY1(16'h0000), .DELAY2(16'h0000),
                       .TIE_RESP(1'b1)) dut2 (
    .clk(clk), .rst(rst[2]), .ch_valid(ch_valid[2]), .ch_ready(ch_ready[2]),
    .challenge(challenge[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp(resp_w[2]), .t1_out(t1_w[2]), .t2_out(t2_w[2]), .eval_count(cnt_w[2]));

  typedef struct {
    int       k;
    logic [3:0] ch;
    int       t1;
    int       t2;
    int       r;
    int       lat;
  } vec_t;

  typedef struct {
    int t1;
    int t2;
    int r;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_cnt [3];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference for instances 0/1: delays 2/3, N=4.
  task automatic model(input logic [3:0] ch, input int tie, output int t1, output int t2,
                       output int r, output int lat);
    int a;
    t1 = 0;
    t2 = 0;
    for (int i = 0; i < 4; i++) begin
      if (ch[i]) begin
        t1 = t1 + 2;
        t2 = t2 + 3;
      end else begin
        a  = t1;
        t1 = t2 + 2;
        t2 = a + 3;
      end
    end
    r   = (t1 < t2) ? 1 : (t1 > t2) ? 0 : tie;
    lat = 4 + ((t1 < t2) ? t1 : t2) + 1;
  endtask

  task automatic run_eval(input int k, input logic [3:0] ch, input int e_t1, input int e_t2,
                          input int e_r, input int e_lat, input int hold);
    exp_t e;
    int   edges;
    bit   got;
    e.t1 = e_t1; e.t2 = e_t2; e.r = e_r; e.lat = e_lat;
    sb.push_back(e);

    @(negedge clk);
    ch_valid[k]  = 1'b1;
    challenge[k] = ch;
    check("ch_ready_idle", int'(ch_ready[k]), 1);
    @(posedge clk);
    #1;
    ch_valid[k]  = 1'b0;
    challenge[k] = ~ch;
    check("ch_ready_busy", int'(ch_ready[k]), 0);

    edges = 0;
    got   = 1'b0;
    while (!got && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (resp_valid[k]) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check("resp_timeout", 0, 1);
      return;
    end
    check("latency", edges, e.lat);
    check("t1_out", int'(t1_w[k]), e.t1);
    check("t2_out", int'(t2_w[k]), e.t2);
    check("resp", int'(resp_w[k]), e.r);

    for (int h = 0; h < hold; h++) begin
      ch_valid[k]  = h[0];
      challenge[k] = 4'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", int'(resp_valid[k]), 1);
      check("hold_ch_ready", int'(ch_ready[k]), 0);
      check("hold_resp", int'(resp_w[k]), e.r);
      check("hold_t1", int'(t1_w[k]), e.t1);
      check("hold_t2", int'(t2_w[k]), e.t2);
    end

    ch_valid[k]   = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    if (exp_cnt[k] != 16'hFFFF) exp_cnt[k]++;
    check("eval_count", int'(cnt_w[k]), exp_cnt[k]);
    check("released_valid", int'(resp_valid[k]), 0);
    check("released_ready", int'(ch_ready[k]), 1);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_ch_ready", int'(ch_ready[k]), 1);
    check("rst_resp_valid", int'(resp_valid[k]), 0);
    check("rst_resp", int'(resp_w[k]), 0);
    check("rst_t1", int'(t1_w[k]), 0);
    check("rst_t2", int'(t2_w[k]), 0);
    check("rst_eval_count", int'(cnt_w[k]), 0);
  endtask

  vec_t tbl [7];

  initial begin
    int t1, t2, r, lat, seen;
    logic [3:0] rc;

    tbl[0] = '{0, 4'b1111,  8, 12, 1, 13};
    tbl[1] = '{0, 4'b0000, 10, 10, 0, 15};
    tbl[2] = '{1, 4'b0000, 10, 10, 1, 15};
    tbl[3] = '{0, 4'b0111, 11,  9, 0, 14};
    tbl[4] = '{1, 4'b1111,  8, 12, 1, 13};
    tbl[5] = '{2, 4'b1010,  0,  0, 1,  5};
    tbl[6] = '{2, 4'b0101,  0,  0, 1,  5};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; ch_valid[k] = 1'b0; challenge[k] = '0;
      resp_ready[k] = 1'b0; exp_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_outputs(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int i = 0; i < 7; i++)
      run_eval(tbl[i].k, tbl[i].ch, tbl[i].t1, tbl[i].t2, tbl[i].r, tbl[i].lat, 0);

    for (int i = 0; i < 4; i++) begin
      rc = 4'($urandom);
      model(rc, 0, t1, t2, r, lat);
      run_eval(0, rc, t1, t2, r, lat, 0);
    end

    // Response held in DONE for 5 cycles with ch_valid/challenge toggling.
    run_eval(0, 4'b1111, 8, 12, 1, 13, 5);

    // Reset asserted mid-RACE on instance 0.
    @(negedge clk);
    ch_valid[0]  = 1'b1;
    challenge[0] = 4'b1111;
    @(posedge clk);
    #1;
    ch_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("racing_no_valid", int'(resp_valid[0]), 0);
    rst[0] = 1'b1;
    #1;
    check_reset_outputs(0);
    for (int h = 0; h < 3; h++) begin
      ch_valid[0]  = ~ch_valid[0];
      challenge[0] = 4'($urandom);
      @(posedge clk);
      #1;
      check_reset_outputs(0);
    end
    @(negedge clk);
    ch_valid[0] = 1'b0;
    rst[0]      = 1'b0;
    exp_cnt[0]  = 0;
    run_eval(0, 4'b1111, 8, 12, 1, 13, 0);

    // Back-to-back on zero-delay instance: 7 edges per evaluation.
    @(negedge clk);
    ch_valid[2]   = 1'b1;
    challenge[2]  = 4'b0110;
    resp_ready[2] = 1'b1;
    seen = 0;
    for (int e = 0; e < 70; e++) begin
      @(posedge clk);
      #1;
      if (resp_valid[2]) begin
        seen++;
        check("b2b_resp", int'(resp_w[2]), 1);
      end
    end
    ch_valid[2]   = 1'b0;
    resp_ready[2] = 1'b0;
    check("b2b_done_count", seen, 10);
    exp_cnt[2] += 10;
    check("b2b_eval_count", int'(cnt_w[2]), exp_cnt[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
